vote_controller: RTL and testbench
==================================

VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 Parameters: N_CAND, default 4, number of candidates; CNT_W, default 4, tally width per candidate.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ballot_en  input  1  officer ballot issue; rising edge arms one vote.
REQ-005 close_poll  input  1  level; ends polling when seen in IDLE.
REQ-006 btn  input  N_CAND  candidate buttons, already synchronised, one bit per candidate.
REQ-007 rd_sel  input  log2(N_CAND)  candidate index for tally readout.
REQ-008 ready  output  1  high in ARMED (voter may press).
REQ-009 busy  output  1  high in CLEAR, WRITE, ACK, RELEASE.
REQ-010 vote_done  output  1  one-cycle pulse, vote recorded or saturated.
REQ-011 vote_err  output  1  one-cycle pulse, multi-button press rejected.
REQ-012 overflow  output  1  sticky, set when any tally would exceed 2^CNT_W-1.
REQ-013 poll_closed  output  1  high in CLOSED.
REQ-014 rd_count  output  CNT_W  tally of candidate rd_sel; valid only when poll_closed=1, else 0.

Function
REQ-015 States: CLEAR, IDLE, ARMED, WRITE, ACK, RELEASE, CLOSED; all outputs Moore-decoded from state plus registered flags.
REQ-016 CLEAR: drive write_enable=1, data_in=0 to all N_CAND tally blocks for exactly one cycle, then go to IDLE.
REQ-017 IDLE: close_poll=1 -> CLOSED (priority over ballot); else ballot_en rising edge (ballot_en=1, registered previous=0) -> ARMED.
REQ-018 ARMED: btn==0 -> stay; btn one-hot -> latch index, go to WRITE; more than one bit set -> vote_err pulse next cycle, stay ARMED; close_poll ignored.
REQ-019 WRITE: if latched tally < 2^CNT_W-1, assert write_enable on that block only with data_in=tally+1 for one cycle; else no write and overflow set; go to ACK.
REQ-020 ACK: vote_done=1 for exactly one cycle; go to RELEASE.
REQ-021 RELEASE: stay until btn==0, then IDLE; a second press cannot produce a second vote for one ballot.
REQ-022 Latency: one-hot btn sampled at edge k -> tally updated at edge k+1 -> vote_done high in cycle after edge k+1.
REQ-023 CLOSED: terminal until reset; ballot_en and btn ignored; rd_count reflects tally[rd_sel] combinationally.
REQ-024 Tally arithmetic is unsigned CNT_W-bit, saturating at 2^CNT_W-1; never wraps.
REQ-025 Exactly one tally block written per ballot; no write occurs outside CLEAR and WRITE.

Reset
REQ-026 reset=1 forces state CLEAR, ready=0, busy=1, vote_done=0, vote_err=0, overflow=0, poll_closed=0, rd_count=0, latched index 0, ballot_en history 0.
REQ-027 Tally storage has no reset of its own; it is cleared only by the CLEAR cycle following reset release.
REQ-028 reset asserted mid-vote (ARMED/WRITE/ACK) aborts the vote; no partial tally write survives, all tallies read 0 after CLEAR.

Structure
REQ-029 Shared package evm_pkg holds the state enum, N_CAND and CNT_W defaults, and the saturation constant.
REQ-030 Tally storage is N_CAND instances of the existing memory_block_4bit sub-module (data_in, write_enable, clk, data_out); the controller owns all sequencing.

Verification
REQ-031 Reset, release: busy=1 one cycle, then IDLE; close poll, read all rd_sel -> rd_count=0.
REQ-032 Ballot, btn=4'b0100, release, close: rd_sel=2 -> 1, others 0; vote_done one pulse exactly 2 cycles after press sampled.
REQ-033 Ballot, btn=4'b0011 -> vote_err pulse, state ARMED, no tally change; then btn=4'b0001 -> candidate 0 = 1.
REQ-034 Sixteen ballots for candidate 3 -> rd_count=15, overflow=1 after 16th, vote_done still pulses.
REQ-035 Hold btn=4'b1000 across two ballot_en pulses without release -> only one vote counted; ballot_en held high -> no re-arm.
REQ-036 Reset asserted in WRITE after three recorded votes -> all tallies 0 after close; close_poll in ARMED ignored until vote completes.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and constants for the electronic voting controller.
// Holds the controller state encoding, default sizing and tally saturation helper.
package evm_pkg;

   localparam int N_CAND_DEF = 4;
   localparam int CNT_W_DEF  = 4;

   typedef enum logic [2:0] {
      S_CLEAR   = 3'd0,
      S_IDLE    = 3'd1,
      S_ARMED   = 3'd2,
      S_WRITE   = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5,
      S_CLOSED  = 3'd6
   } state_t;

   function automatic int unsigned sat_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   localparam int unsigned SAT_MAX = sat_max(CNT_W_DEF);

endpackage

// File: rtl/memory_block_4bit.sv
// Single tally register: loads data_in on a clock edge with write_enable high.
// Deliberately has no reset; the controller clears it with an explicit write.
module memory_block_4bit #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         write_enable,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (write_enable) begin
         data_out <= data_in;
      end
   end

endmodule

// File: rtl/vote_controller.sv
// Ballot sequencing controller: arms one vote per ballot_en edge, records a
// single one-hot button press into saturating per-candidate tallies.
module vote_controller
   import evm_pkg::*;
#(
   parameter int N_CAND = N_CAND_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ballot_en,
   input  logic                      close_poll,
   input  logic [N_CAND-1:0]         btn,
   input  logic [$clog2(N_CAND)-1:0] rd_sel,
   output logic                      ready,
   output logic                      busy,
   output logic                      vote_done,
   output logic                      vote_err,
   output logic                      overflow,
   output logic                      poll_closed,
   output logic [CNT_W-1:0]          rd_count
);

   localparam int               SEL_W     = $clog2(N_CAND);
   localparam logic [CNT_W-1:0] TALLY_MAX = CNT_W'(sat_max(CNT_W));

   state_t             state;
   state_t             state_n;
   logic               ballot_prev;
   logic [SEL_W-1:0]   sel_idx;
   logic [SEL_W-1:0]   btn_idx;
   logic               btn_onehot;
   logic               btn_multi;
   logic               sel_full;
   logic               vote_err_r;
   logic               overflow_r;
   logic [CNT_W-1:0]   tally [N_CAND];
   logic [CNT_W-1:0]   wr_data;
   logic [N_CAND-1:0]  wr_en;

   assign btn_onehot = $onehot(btn);
   assign btn_multi  = (btn != '0) && !btn_onehot;
   assign sel_full   = (tally[sel_idx] == TALLY_MAX);

   always_comb begin
      btn_idx = '0;
      for (int i = 0; i < N_CAND; i++) begin
         if (btn[i]) begin
            btn_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_CLEAR:   state_n = S_IDLE;
         S_IDLE: begin
            if (close_poll) begin
               state_n = S_CLOSED;
            end else if (ballot_en && !ballot_prev) begin
               state_n = S_ARMED;
            end
         end
         S_ARMED: begin
            if (btn_onehot) begin
               state_n = S_WRITE;
            end
         end
         S_WRITE:   state_n = S_ACK;
         S_ACK:     state_n = S_RELEASE;
         S_RELEASE: begin
            if (btn == '0) begin
               state_n = S_IDLE;
            end
         end
         S_CLOSED:  state_n = S_CLOSED;
         default:   state_n = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_CLEAR;
         ballot_prev <= 1'b0;
         sel_idx     <= '0;
         vote_err_r  <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state       <= state_n;
         ballot_prev <= ballot_en;
         vote_err_r  <= (state == S_ARMED) && btn_multi;
         if ((state == S_ARMED) && btn_onehot) begin
            sel_idx <= btn_idx;
         end
         if ((state == S_WRITE) && sel_full) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // CLEAR broadcasts zero to every block; WRITE touches only the latched one.
   always_comb begin
      wr_data = (state == S_CLEAR) ? '0 : tally[sel_idx] + 1'b1;
      for (int i = 0; i < N_CAND; i++) begin
         wr_en[i] = (state == S_CLEAR) ||
                    ((state == S_WRITE) && !sel_full && (sel_idx == SEL_W'(i)));
      end
   end

   generate
      for (genvar g = 0; g < N_CAND; g++) begin : g_tally
         memory_block_4bit #(
            .W (CNT_W)
         ) u_blk (
            .clk          (clk),
            .write_enable (wr_en[g]),
            .data_in      (wr_data),
            .data_out     (tally[g])
         );
      end
   endgenerate

   assign ready       = (state == S_ARMED);
   assign busy        = (state == S_CLEAR) || (state == S_WRITE) ||
                        (state == S_ACK)   || (state == S_RELEASE);
   assign vote_done   = (state == S_ACK);
   assign vote_err    = vote_err_r;
   assign overflow    = overflow_r;
   assign poll_closed = (state == S_CLOSED);
   assign rd_count    = poll_closed ? tally[rd_sel] : '0;

endmodule

// File: tb/tb_vote_controller.sv
// Self-checking bench for vote_controller: per-cycle vector table plus
// directed sequences for saturation, held buttons and mid-vote reset.
module tb_vote_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ballot_en = 1'b0;
   logic       close_poll = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [1:0] rd_sel = 2'd0;
   logic       ready, busy, vote_done, vote_err, overflow, poll_closed;
   logic [3:0] rd_count;

   int tests = 0;
   int fails = 0;

   vote_controller #(.N_CAND(4), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .ballot_en   (ballot_en),
      .close_poll  (close_poll),
      .btn         (btn),
      .rd_sel      (rd_sel),
      .ready       (ready),
      .busy        (busy),
      .vote_done   (vote_done),
      .vote_err    (vote_err),
      .overflow    (overflow),
      .poll_closed (poll_closed),
      .rd_count    (rd_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // flags = {ready, busy, vote_done, vote_err, overflow, poll_closed}
   typedef struct {
      string      name;
      logic       rst;
      logic       ben;
      logic       cp;
      logic [3:0] btn;
      logic [1:0] sel;
      logic [5:0] flags;
      logic [3:0] cnt;
   } vec_t;

   vec_t vtab[$];

   task automatic add(input string n, input logic r, input logic b, input logic c,
                      input logic [3:0] bt, input logic [1:0] s,
                      input logic [5:0] f, input logic [3:0] cn);
      vec_t v;
      v.name = n; v.rst = r; v.ben = b; v.cp = c; v.btn = bt; v.sel = s;
      v.flags = f; v.cnt = cn;
      vtab.push_back(v);
   endtask

   task automatic chk(input string n, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] flags_now();
      return {ready, busy, vote_done, vote_err, overflow, poll_closed};
   endfunction

   task automatic do_reset();
      reset = 1'b1; ballot_en = 1'b0; close_poll = 1'b0; btn = 4'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_vote(input logic [3:0] v, input string n);
      ballot_en = 1'b1;
      step();
      ballot_en = 1'b0;
      btn = v;
      step();
      btn = 4'b0;
      step();
      chk({n, "_done"}, vote_done, 1);
      step();
      step();
   endtask

   task automatic close_and_read(input logic [3:0] exp0, input logic [3:0] exp1,
                                 input logic [3:0] exp2, input logic [3:0] exp3,
                                 input string n);
      logic [3:0] e [4];
      e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3;
      close_poll = 1'b1;
      step();
      chk({n, "_closed"}, poll_closed, 1);
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         chk($sformatf("%s_rd%0d", n, i), rd_count, e[i]);
      end
      close_poll = 1'b0;
   endtask

   initial begin
      // Reset, release, close immediately: all tallies zero; CLOSED ignores inputs.
      add("rst_a",   1, 0, 0, 4'b0000, 0, 6'b010000, 0);
      add("idle_a",  0, 0, 0, 4'b0000, 0, 6'b000000, 0);
      add("close_a", 0, 0, 1, 4'b0000, 0, 6'b000001, 0);
      add("rd1_a",   0, 0, 1, 4'b0000, 1, 6'b000001, 0);
      add("ign_a",   0, 1, 1, 4'b0001, 2, 6'b000001, 0);
      add("rd3_a",   0, 0, 0, 4'b1000, 3, 6'b000001, 0);
      // Single vote for candidate 2.
      add("rst_b",   1, 0, 0, 4'b0000, 0, 6'b010000, 0);
      add("idle_b",  0, 0, 0, 4'b0000, 0, 6'b000000, 0);
      add("arm_b",   0, 1, 0, 4'b0000, 0, 6'b100000, 0);
      add("write_b", 0, 0, 0, 4'b0100, 0, 6'b010000, 0);
      add("ack_b",   0, 0, 0, 4'b0100, 0, 6'b011000, 0);
      add("rel_b",   0, 0, 0, 4'b0100, 0, 6'b010000, 0);
      add("idle2_b", 0, 0, 0, 4'b0000, 0, 6'b000000, 0);
      add("rd2_b",   0, 0, 1, 4'b0000, 2, 6'b000001, 1);
      add("rd0_b",   0, 0, 1, 4'b0000, 0, 6'b000001, 0);
      add("rd1_b",   0, 0, 1, 4'b0000, 1, 6'b000001, 0);
      add("rd3_b",   0, 0, 1, 4'b0000, 3, 6'b000001, 0);
      // Multi-button rejection, then valid vote for candidate 0.
      add("rst_c",   1, 0, 0, 4'b0000, 0, 6'b010000, 0);
      add("idle_c",  0, 0, 0, 4'b0000, 0, 6'b000000, 0);
      add("arm_c",   0, 1, 0, 4'b0000, 0, 6'b100000, 0);
      add("multi_c", 0, 0, 0, 4'b0011, 0, 6'b100100, 0);
      add("armd_c",  0, 0, 0, 4'b0000, 0, 6'b100000, 0);
      add("write_c", 0, 0, 0, 4'b0001, 0, 6'b010000, 0);
      add("ack_c",   0, 0, 0, 4'b0000, 0, 6'b011000, 0);
      add("rel_c",   0, 0, 0, 4'b0000, 0, 6'b010000, 0);
      add("idle2_c", 0, 0, 0, 4'b0000, 0, 6'b000000, 0);
      add("rd0_c",   0, 0, 1, 4'b0000, 0, 6'b000001, 1);
      add("rd1_c",   0, 0, 1, 4'b0000, 1, 6'b000001, 0);
      add("rd2_c",   0, 0, 1, 4'b0000, 2, 6'b000001, 0);
      add("rd3_c",   0, 0, 1, 4'b0000, 3, 6'b000001, 0);

      // Asynchronous reset is visible before any clock edge.
      #1;
      chk("async_rst_busy", busy, 1);
      chk("async_rst_ready", ready, 0);
      chk("async_rst_rd", rd_count, 0);

      foreach (vtab[i]) begin
         reset = vtab[i].rst; ballot_en = vtab[i].ben; close_poll = vtab[i].cp;
         btn = vtab[i].btn; rd_sel = vtab[i].sel;
         step();
         chk({vtab[i].name, "_flags"}, flags_now(), vtab[i].flags);
         chk({vtab[i].name, "_cnt"}, rd_count, vtab[i].cnt);
      end

      // Saturation: sixteen votes for candidate 3.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         do_vote(4'b1000, $sformatf("sat%0d", i));
      end
      chk("sat_no_ovf_15", overflow, 0);
      chk("sat_rd_gated", rd_count, 0);
      do_vote(4'b1000, "sat15");
      chk("sat_ovf_16", overflow, 1);
      close_and_read(4'd0, 4'd0, 4'd0, 4'd15, "sat");
      chk("sat_ovf_sticky", overflow, 1);

      // Held button across a second ballot pulse, then ballot_en held high.
      do_reset();
      ballot_en = 1'b1; step();
      ballot_en = 1'b0; btn = 4'b1000; step();
      step(); step();
      chk("hold_release", flags_now(), 6'b010000);
      ballot_en = 1'b1; step();
      ballot_en = 1'b0; step(); step();
      chk("hold_no_rearm", flags_now(), 6'b010000);
      btn = 4'b0000; step(); step();
      chk("hold_idle", flags_now(), 6'b000000);
      ballot_en = 1'b1; step();
      chk("lvl_arm", ready, 1);
      btn = 4'b1000; step();
      btn = 4'b0000; step(); step(); step(); step(); step();
      chk("lvl_no_rearm", flags_now(), 6'b000000);
      ballot_en = 1'b0;
      close_and_read(4'd0, 4'd0, 4'd0, 4'd2, "hold");

      // close_poll in ARMED is ignored until the vote completes.
      do_reset();
      ballot_en = 1'b1; step();
      ballot_en = 1'b0; close_poll = 1'b1; step(); step();
      chk("cp_armed", flags_now(), 6'b100000);
      btn = 4'b0010; step();
      btn = 4'b0000; step();
      chk("cp_done", vote_done, 1);
      step(); step();
      chk("cp_idle", flags_now(), 6'b000000);
      step();
      chk("cp_closed", poll_closed, 1);
      rd_sel = 2'd1; #1;
      chk("cp_rd1", rd_count, 1);
      close_poll = 1'b0;

      // Reset asserted in WRITE after three recorded votes.
      do_reset();
      do_vote(4'b0001, "mid0");
      do_vote(4'b0010, "mid1");
      do_vote(4'b0100, "mid2");
      ballot_en = 1'b1; step();
      ballot_en = 1'b0; btn = 4'b1000; step();
      chk("mid_in_write", flags_now(), 6'b010000);
      reset = 1'b1; btn = 4'b0000; #1;
      chk("mid_rst_flags", flags_now(), 6'b010000);
      step();
      reset = 1'b0;
      step();
      close_and_read(4'd0, 4'd0, 4'd0, 4'd0, "mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
